pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the fetch/decode/execute pipeline. It generates the clock-enable, stall and flush controls for each stage. It detects load-use hazards, branch/jump redirects, multi-cycle ALU busy and halt instructions. It runs a small FSM (idle, run, flush-drain, ALU-wait, halt) so that the stages themselves carry no control policy.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 52 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 31 +++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, load opcode,
// and the CTL_PERF_CNT_EN build switch exposed as a constant.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } ctl_state_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

`ifdef CTL_PERF_CNT_EN
  localparam bit PERF_CNT_EN = 1'b1;
`else
  localparam bit PERF_CNT_EN = 1'b0;
`endif

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bus between the pipeline stages and pipeline_ctrl.
// master = pipeline side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int AWIDTH       = 5,
  parameter int OPCODE_WIDTH = 7,
  parameter int CNT_WIDTH    = 32
);
  logic                    ctl_i_start;
  logic                    ctl_i_de_valid;
  logic                    ctl_i_de_halt;
  logic [AWIDTH-1:0]       ctl_i_de_addr_rs1;
  logic [AWIDTH-1:0]       ctl_i_de_addr_rs2;
  logic                    ctl_i_de_use_rs1;
  logic                    ctl_i_de_use_rs2;
  logic                    ctl_i_ex_valid;
  logic [OPCODE_WIDTH-1:0] ctl_i_ex_opcode;
  logic [AWIDTH-1:0]       ctl_i_ex_addr_rd;
  logic                    ctl_i_ex_we;
  logic                    ctl_i_ex_change_pc;
  logic                    ctl_i_ex_stall_alu;

  logic                    ctl_o_ce_fetch;
  logic                    ctl_o_ce_execute;
  logic                    ctl_o_stall_fetch;
  logic                    ctl_o_stall_decode;
  logic                    ctl_o_flush_decode;
  logic                    ctl_o_flush_execute;
  logic                    ctl_o_halted;
  logic [2:0]              ctl_o_state;
  logic [CNT_WIDTH-1:0]    ctl_o_stall_cnt;
  logic [CNT_WIDTH-1:0]    ctl_o_flush_cnt;

  modport master (
    output ctl_i_start, ctl_i_de_valid, ctl_i_de_halt,
           ctl_i_de_addr_rs1, ctl_i_de_addr_rs2, ctl_i_de_use_rs1, ctl_i_de_use_rs2,
           ctl_i_ex_valid, ctl_i_ex_opcode, ctl_i_ex_addr_rd, ctl_i_ex_we,
           ctl_i_ex_change_pc, ctl_i_ex_stall_alu,
    input  ctl_o_ce_fetch, ctl_o_ce_execute, ctl_o_stall_fetch, ctl_o_stall_decode,
           ctl_o_flush_decode, ctl_o_flush_execute, ctl_o_halted, ctl_o_state,
           ctl_o_stall_cnt, ctl_o_flush_cnt
  );

  modport slave (
    input  ctl_i_start, ctl_i_de_valid, ctl_i_de_halt,
           ctl_i_de_addr_rs1, ctl_i_de_addr_rs2, ctl_i_de_use_rs1, ctl_i_de_use_rs2,
           ctl_i_ex_valid, ctl_i_ex_opcode, ctl_i_ex_addr_rd, ctl_i_ex_we,
           ctl_i_ex_change_pc, ctl_i_ex_stall_alu,
    output ctl_o_ce_fetch, ctl_o_ce_execute, ctl_o_stall_fetch, ctl_o_stall_decode,
           ctl_o_flush_decode, ctl_o_flush_execute, ctl_o_halted, ctl_o_state,
           ctl_o_stall_cnt, ctl_o_flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose rd (non-x0) is read
// by the instruction in DE.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    de_valid,
  input  logic [AWIDTH-1:0]       de_addr_rs1,
  input  logic [AWIDTH-1:0]       de_addr_rs2,
  input  logic                    de_use_rs1,
  input  logic                    de_use_rs2,
  input  logic                    ex_valid,
  input  logic [OPCODE_WIDTH-1:0] ex_opcode,
  input  logic [AWIDTH-1:0]       ex_addr_rd,
  input  logic                    ex_we,
  output logic                    load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  assign ex_is_load = ex_valid && ex_we && (ex_opcode == OPCODE_WIDTH'(OP_LOAD))
                      && (ex_addr_rd != '0);
  assign rs1_hit    = de_use_rs1 && (de_addr_rs1 == ex_addr_rd);
  assign rs2_hit    = de_use_rs2 && (de_addr_rs2 == ex_addr_rd);
  assign load_use   = de_valid && ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller. Optional perf counters are built
// only when CTL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int OPCODE_WIDTH = 7,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input logic           ctl_clk,
  input logic           ctl_rst,
  pipeline_ctrl_if.slave bus
);

  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  ctl_state_e     state_reg, state_next;
  logic [FCW-1:0] flush_cnt_reg, flush_cnt_next;

  logic load_use;
  logic redirect;
  logic halt_req;
  logic ce_fetch, ce_execute, stall_fetch, stall_decode;
  logic flush_decode, flush_execute, halted;

  pipeline_ctrl_hazard_detect #(
    .AWIDTH      (AWIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_hazard (
    .de_valid   (bus.ctl_i_de_valid),
    .de_addr_rs1(bus.ctl_i_de_addr_rs1),
    .de_addr_rs2(bus.ctl_i_de_addr_rs2),
    .de_use_rs1 (bus.ctl_i_de_use_rs1),
    .de_use_rs2 (bus.ctl_i_de_use_rs2),
    .ex_valid   (bus.ctl_i_ex_valid),
    .ex_opcode  (bus.ctl_i_ex_opcode),
    .ex_addr_rd (bus.ctl_i_ex_addr_rd),
    .ex_we      (bus.ctl_i_ex_we),
    .load_use   (load_use)
  );

  assign redirect = bus.ctl_i_ex_valid && bus.ctl_i_ex_change_pc;
  assign halt_req = bus.ctl_i_de_valid && bus.ctl_i_de_halt;

  always_ff @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    ce_fetch       = 1'b0;
    ce_execute     = 1'b0;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    flush_decode   = 1'b0;
    flush_execute  = 1'b0;
    halted         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.ctl_i_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        ce_fetch   = 1'b1;
        ce_execute = 1'b1;
        // Strict priority: a redirect squashes any younger hazard or halt.
        if (redirect) begin
          flush_decode  = 1'b1;
          flush_execute = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = FLUSH_LOAD;
          end
        end else if (bus.ctl_i_ex_stall_alu) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          state_next   = ST_ALU_WAIT;
        end else if (load_use) begin
          stall_fetch   = 1'b1;
          stall_decode  = 1'b1;
          flush_execute = 1'b1;
        end else if (halt_req) begin
          stall_fetch = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_FLUSH: begin
        ce_fetch      = 1'b1;
        ce_execute    = 1'b1;
        flush_decode  = 1'b1;
        flush_execute = 1'b1;
        if (flush_cnt_reg == '0) state_next = ST_RUN;
        else flush_cnt_next = flush_cnt_reg - 1'b1;
      end
      ST_ALU_WAIT: begin
        ce_fetch     = 1'b1;
        ce_execute   = 1'b1;
        stall_fetch  = bus.ctl_i_ex_stall_alu;
        stall_decode = bus.ctl_i_ex_stall_alu;
        if (!bus.ctl_i_ex_stall_alu) state_next = ST_RUN;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (bus.ctl_i_start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.ctl_o_ce_fetch      = ce_fetch;
  assign bus.ctl_o_ce_execute    = ce_execute;
  assign bus.ctl_o_stall_fetch   = stall_fetch;
  assign bus.ctl_o_stall_decode  = stall_decode;
  assign bus.ctl_o_flush_decode  = flush_decode;
  assign bus.ctl_o_flush_execute = flush_execute;
  assign bus.ctl_o_halted        = halted;
  assign bus.ctl_o_state         = state_reg;

`ifdef CTL_PERF_CNT_EN
  // Index 0 counts stall_fetch cycles, index 1 counts flush_execute cycles.
  logic [1:0]           perf_evt;
  logic [CNT_WIDTH-1:0] perf_cnt_reg [2];

  assign perf_evt = {flush_execute, stall_fetch};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
      if (ctl_rst) begin
        perf_cnt_reg[gi] <= '0;
      end else if (perf_evt[gi] && (perf_cnt_reg[gi] != '1)) begin
        perf_cnt_reg[gi] <= perf_cnt_reg[gi] + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.ctl_o_stall_cnt = perf_cnt_reg[0];
  assign bus.ctl_o_flush_cnt = perf_cnt_reg[1];
`else
  assign bus.ctl_o_stall_cnt = '0;
  assign bus.ctl_o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, redirect, ALU wait, halt,
// counters and mid-flush reset against hand-computed expectations.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int OW = 7;
  localparam int CW = 32;

  logic ctl_clk = 1'b0;
  logic ctl_rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_ctrl_if #(.AWIDTH(AW), .OPCODE_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

  pipeline_ctrl #(
    .AWIDTH      (AW),
    .OPCODE_WIDTH(OW),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (CW)
  ) dut (
    .ctl_clk(ctl_clk),
    .ctl_rst(ctl_rst),
    .bus    (bus)
  );

  always #5 ctl_clk = ~ctl_clk;

  // Packed control view: {ce_fetch, ce_execute, stall_fetch, stall_decode,
  //                       flush_decode, flush_execute, halted}
  logic [6:0] ctl_vec;
  assign ctl_vec = {bus.ctl_o_ce_fetch, bus.ctl_o_ce_execute, bus.ctl_o_stall_fetch,
                    bus.ctl_o_stall_decode, bus.ctl_o_flush_decode,
                    bus.ctl_o_flush_execute, bus.ctl_o_halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ctl_i_start        = 1'b0;
    bus.ctl_i_de_valid     = 1'b0;
    bus.ctl_i_de_halt      = 1'b0;
    bus.ctl_i_de_addr_rs1  = '0;
    bus.ctl_i_de_addr_rs2  = '0;
    bus.ctl_i_de_use_rs1   = 1'b0;
    bus.ctl_i_de_use_rs2   = 1'b0;
    bus.ctl_i_ex_valid     = 1'b0;
    bus.ctl_i_ex_opcode    = '0;
    bus.ctl_i_ex_addr_rd   = '0;
    bus.ctl_i_ex_we        = 1'b0;
    bus.ctl_i_ex_change_pc = 1'b0;
    bus.ctl_i_ex_stall_alu = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic set_load(input logic [AW-1:0] rd, input logic [AW-1:0] rs1);
    bus.ctl_i_ex_valid    = 1'b1;
    bus.ctl_i_ex_we       = 1'b1;
    bus.ctl_i_ex_opcode   = 7'b0000011;
    bus.ctl_i_ex_addr_rd  = rd;
    bus.ctl_i_de_valid    = 1'b1;
    bus.ctl_i_de_use_rs1  = 1'b1;
    bus.ctl_i_de_addr_rs1 = rs1;
  endtask

  initial begin
    clear_inputs();
    #12;
    check("rst_state", 32'(bus.ctl_o_state), 32'd0);
    check("rst_ctl", 32'(ctl_vec), 32'b0000000);
    check("rst_stallcnt", bus.ctl_o_stall_cnt, 32'd0);

    step();
    ctl_rst = 1'b0;
    step();
    bus.ctl_i_start = 1'b1;
    #1;
    check("idle_state", 32'(bus.ctl_o_state), 32'd0);
    check("idle_ctl", 32'(ctl_vec), 32'b0000000);
    step();
    bus.ctl_i_start = 1'b0;
    #1;
    check("run_state", 32'(bus.ctl_o_state), 32'd1);
    check("run_ctl", 32'(ctl_vec), 32'b1100000);

    // Load-use on rs1 = rd = 5: one bubble.
    set_load(5'd5, 5'd5);
    #1;
    check("lduse_ctl", 32'(ctl_vec), 32'b1111010);
    step();
    clear_inputs();
    #1;
    check("lduse_state", 32'(bus.ctl_o_state), 32'd1);
    check("lduse_after", 32'(ctl_vec), 32'b1100000);

    // Same pattern with rd = x0: no hazard.
    set_load(5'd0, 5'd0);
    #1;
    check("x0_ctl", 32'(ctl_vec), 32'b1100000);
    step();
    clear_inputs();

    // Redirect with a same-cycle halt: two flush cycles, no HALT.
    bus.ctl_i_ex_valid     = 1'b1;
    bus.ctl_i_ex_change_pc = 1'b1;
    bus.ctl_i_de_valid     = 1'b1;
    bus.ctl_i_de_halt      = 1'b1;
    #1;
    check("redir_ctl0", 32'(ctl_vec), 32'b1100110);
    step();
    clear_inputs();
    #1;
    check("redir_state1", 32'(bus.ctl_o_state), 32'd2);
    check("redir_ctl1", 32'(ctl_vec), 32'b1100110);
    step();
    check("redir_state2", 32'(bus.ctl_o_state), 32'd1);
    check("redir_ctl2", 32'(ctl_vec), 32'b1100000);

    // ALU busy for 4 cycles.
    bus.ctl_i_ex_stall_alu = 1'b1;
    #1;
    check("alu_ctl0", 32'(ctl_vec), 32'b1111000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("alu_state", 32'(bus.ctl_o_state), 32'd3);
      check("alu_ctl", 32'(ctl_vec), 32'b1111000);
    end
    step();
    bus.ctl_i_ex_stall_alu = 1'b0;
    #1;
    check("alu_release", 32'(ctl_vec), 32'b1100000);
    check("alu_rel_state", 32'(bus.ctl_o_state), 32'd3);
    step();
    check("alu_back_run", 32'(bus.ctl_o_state), 32'd1);

    // Halt.
    bus.ctl_i_de_valid = 1'b1;
    bus.ctl_i_de_halt  = 1'b1;
    #1;
    check("halt_ctl0", 32'(ctl_vec), 32'b1110000);
    step();
    clear_inputs();
    #1;
    check("halt_state", 32'(bus.ctl_o_state), 32'd4);
    check("halt_ctl", 32'(ctl_vec), 32'b0000001);
    step();
    check("halt_hold", 32'(bus.ctl_o_state), 32'd4);

    check("stall_cnt", bus.ctl_o_stall_cnt, PERF_CNT_EN ? 32'd6 : 32'd0);
    check("flush_cnt", bus.ctl_o_flush_cnt, PERF_CNT_EN ? 32'd3 : 32'd0);

    bus.ctl_i_start = 1'b1;
    step();
    bus.ctl_i_start = 1'b0;
    #1;
    check("restart_state", 32'(bus.ctl_o_state), 32'd1);
    check("restart_ctl", 32'(ctl_vec), 32'b1100000);

    // Reset asserted mid-FLUSH aborts immediately.
    bus.ctl_i_ex_valid     = 1'b1;
    bus.ctl_i_ex_change_pc = 1'b1;
    step();
    clear_inputs();
    #1;
    check("pre_rst_state", 32'(bus.ctl_o_state), 32'd2);
    ctl_rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus.ctl_o_state), 32'd0);
    check("mid_rst_ctl", 32'(ctl_vec), 32'b0000000);
    check("mid_rst_scnt", bus.ctl_o_stall_cnt, 32'd0);
    check("mid_rst_fcnt", bus.ctl_o_flush_cnt, 32'd0);
    step();
    ctl_rst = 1'b0;
    step();
    check("post_rst_idle", 32'(bus.ctl_o_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
